// File: rtl/rob_queue_if.sv
// rob_queue_if: decode/execute/retire port bundle of the reorder buffer.
interface rob_queue_if #(
    parameter int rob_num         = 16,
    parameter int rob_data_length = 28
);
    localparam int rob_width = $clog2(rob_num);
    logic                       wr0_en_i;
    logic [rob_width-1:0]       head_addr_o;
    logic                       full_rob_o;
    logic                       wr1_en_i;
    logic [rob_width-1:0]       wr1_addr_i;
    logic [rob_data_length-1:0] wr1_data_i;
    logic                       retire_valid_o;
    logic [rob_data_length-1:0] retire_data_o;
    logic                       retire_ready_i;
    logic                       empty_rob_o;
    logic                       err_o;
    modport slave (
        input  wr0_en_i, wr1_en_i, wr1_addr_i, wr1_data_i, retire_ready_i,
        output head_addr_o, full_rob_o, retire_valid_o, retire_data_o, empty_rob_o, err_o
    );
    modport master (
        output wr0_en_i, wr1_en_i, wr1_addr_i, wr1_data_i, retire_ready_i,
        input  head_addr_o, full_rob_o, retire_valid_o, retire_data_o, empty_rob_o, err_o
    );
endinterface

// File: rtl/rob_queue.sv
// rob_queue: in-order-retire reorder buffer with out-of-order completion.
// Define ROB_QUEUE_ERR_CHK_EN to enable the sticky protocol-error flag err_o.
module rob_queue #(
    parameter int rob_num         = 16,
    parameter int rob_data_length = 28
) (
    input logic       clk,
    input logic       rst,
    rob_queue_if.slave bus
);
    localparam int rob_width = $clog2(rob_num);
    logic [rob_width-1:0]       head_q, head_d, tail_q, tail_d;
    logic [rob_width:0]         count_q, count_d;
    logic [rob_num-1:0]         alloc_q, alloc_d, done_q, done_d;
    logic [rob_data_length-1:0] rec_q [rob_num];
    logic                       alloc_fire, cpl_ok, retire_fire;
    assign bus.full_rob_o     = count_q == (rob_width+1)'(rob_num);
    assign bus.empty_rob_o    = count_q == '0;
    assign bus.head_addr_o    = head_q;
    assign bus.retire_valid_o = !bus.empty_rob_o && done_q[tail_q];
    assign bus.retire_data_o  = rec_q[tail_q];
    assign alloc_fire  = bus.wr0_en_i && !bus.full_rob_o;
    // pre-edge alloc bit gates completion, so a same-cycle allocate+complete is dropped
    assign cpl_ok      = bus.wr1_en_i && alloc_q[bus.wr1_addr_i] && !done_q[bus.wr1_addr_i];
    assign retire_fire = bus.retire_valid_o && bus.retire_ready_i;
    always_comb begin
        head_d  = alloc_fire ? head_q + rob_width'(1) : head_q;
        tail_d  = retire_fire ? tail_q + rob_width'(1) : tail_q;
        count_d = count_q + (rob_width+1)'(alloc_fire) - (rob_width+1)'(retire_fire);
        alloc_d = alloc_q;
        done_d  = done_q;
        if (alloc_fire) begin
            alloc_d[head_q] = 1'b1;
            done_d[head_q]  = 1'b0;
        end
        if (cpl_ok) done_d[bus.wr1_addr_i] = 1'b1;
        if (retire_fire) begin
            alloc_d[tail_q] = 1'b0;
            done_d[tail_q]  = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            alloc_q <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            alloc_q <= alloc_d;
            done_q  <= done_d;
        end
    end
    always_ff @(posedge clk) begin
        if (cpl_ok) rec_q[bus.wr1_addr_i] <= bus.wr1_data_i;
    end
`ifdef ROB_QUEUE_ERR_CHK_EN
    logic err_q, err_d;
    assign err_d = err_q | (bus.wr0_en_i && bus.full_rob_o) | (bus.wr1_en_i && !cpl_ok);
    always_ff @(posedge clk) begin
        err_q <= rst ? 1'b0 : err_d;
    end
    assign bus.err_o = err_q;
`else
    assign bus.err_o = 1'b0;
`endif
endmodule

// File: tb/tb_rob_queue.sv
// tb_rob_queue: directed stimulus with a retire-order scoreboard for rob_queue.
module tb_rob_queue;
    localparam int N = 16;
    localparam int W = 28;
`ifdef ROB_QUEUE_ERR_CHK_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int compared = 0;
    int mismatched = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] held;
    logic [W-1:0] wdat [64];
    rob_queue_if #(.rob_num(N), .rob_data_length(W)) bus ();
    rob_queue #(.rob_num(N), .rob_data_length(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // retire monitor: every accepted record must match the oldest expected one
    always @(negedge clk) begin
        if (!rst && bus.retire_valid_o && bus.retire_ready_i) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL retire_unexpected: got %0h expected no retire at %0t", bus.retire_data_o, $time);
            end else begin
                check("retire_data", 32'(bus.retire_data_o), 32'(exp_q.pop_front()));
            end
        end
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        bus.wr0_en_i = 1'b0;
        bus.wr1_en_i = 1'b0;
        bus.retire_ready_i = 1'b0;
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
    endtask
    task automatic alloc(input logic [W-1:0] d);
        bus.wr0_en_i = 1'b1;
        exp_q.push_back(d);
        step();
        bus.wr0_en_i = 1'b0;
    endtask
    task automatic complete(input logic [3:0] a, input logic [W-1:0] d);
        bus.wr1_en_i = 1'b1;
        bus.wr1_addr_i = a;
        bus.wr1_data_i = d;
        step();
        bus.wr1_en_i = 1'b0;
    endtask
    initial begin
        bus.wr0_en_i = 1'b0;
        bus.wr1_en_i = 1'b0;
        bus.wr1_addr_i = '0;
        bus.wr1_data_i = '0;
        bus.retire_ready_i = 1'b0;
        do_reset();
        check("rst_head", 32'(bus.head_addr_o), 0);
        check("rst_full", 32'(bus.full_rob_o), 0);
        check("rst_empty", 32'(bus.empty_rob_o), 1);
        check("rst_valid", 32'(bus.retire_valid_o), 0);
        check("rst_err", 32'(bus.err_o), 0);
        // fill to full, then one rejected allocation
        bus.wr0_en_i = 1'b1;
        for (int i = 0; i < N; i++) begin
            check("fill_head", 32'(bus.head_addr_o), 32'(i));
            check("fill_full", 32'(bus.full_rob_o), 0);
            step();
        end
        check("full_head", 32'(bus.head_addr_o), 0);
        check("full_flag", 32'(bus.full_rob_o), 1);
        step();
        bus.wr0_en_i = 1'b0;
        check("over_head", 32'(bus.head_addr_o), 0);
        check("over_full", 32'(bus.full_rob_o), 1);
        check("over_err", 32'(bus.err_o), 32'(ERR));
        // full: retire and allocate in the same cycle
        complete(4'd0, 28'h1234567);
        exp_q.push_back(28'h1234567);
        check("fr_valid", 32'(bus.retire_valid_o), 1);
        bus.wr0_en_i = 1'b1;
        bus.retire_ready_i = 1'b1;
        step();
        bus.retire_ready_i = 1'b0;
        check("fr_full", 32'(bus.full_rob_o), 0);
        check("fr_head", 32'(bus.head_addr_o), 0);
        check("fr_empty", 32'(bus.empty_rob_o), 0);
        step();
        bus.wr0_en_i = 1'b0;
        check("fr_head2", 32'(bus.head_addr_o), 1);
        check("fr_full2", 32'(bus.full_rob_o), 1);
        check("fr_sb", 32'(exp_q.size()), 0);
        // out-of-order completion, in-order retire
        do_reset();
        alloc(28'h0A0A0A0);
        alloc(28'h1B1B1B1);
        alloc(28'h2C2C2C2);
        complete(4'd2, 28'h2C2C2C2);
        check("ooo_valid2", 32'(bus.retire_valid_o), 0);
        complete(4'd1, 28'h1B1B1B1);
        check("ooo_valid1", 32'(bus.retire_valid_o), 0);
        complete(4'd0, 28'h0A0A0A0);
        check("ooo_valid0", 32'(bus.retire_valid_o), 1);
        bus.retire_ready_i = 1'b1;
        step();
        check("ooo_r1", 32'(bus.retire_valid_o), 1);
        step();
        check("ooo_r2", 32'(bus.retire_valid_o), 1);
        step();
        bus.retire_ready_i = 1'b0;
        check("ooo_empty", 32'(bus.empty_rob_o), 1);
        check("ooo_valid_end", 32'(bus.retire_valid_o), 0);
        check("ooo_sb", 32'(exp_q.size()), 0);
        // backpressure: record held stable until accepted
        alloc(28'h5566778);
        complete(4'd3, 28'h5566778);
        held = 28'h5566778;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(bus.retire_valid_o), 1);
            check("bp_data", 32'(bus.retire_data_o), 32'(held));
            step();
        end
        bus.retire_ready_i = 1'b1;
        step();
        bus.retire_ready_i = 1'b0;
        check("bp_empty", 32'(bus.empty_rob_o), 1);
        check("bp_head", 32'(bus.head_addr_o), 4);
        // rejected completions: unallocated, same-cycle, and duplicate
        do_reset();
        complete(4'd5, 28'h0000ABC);
        check("unalloc_err", 32'(bus.err_o), 32'(ERR));
        check("unalloc_empty", 32'(bus.empty_rob_o), 1);
        check("unalloc_valid", 32'(bus.retire_valid_o), 0);
        bus.wr1_en_i = 1'b1;
        bus.wr1_addr_i = 4'd0;
        bus.wr1_data_i = 28'hDEADBEE;
        alloc(28'h1000000);
        bus.wr1_en_i = 1'b0;
        check("same_cyc_valid", 32'(bus.retire_valid_o), 0);
        for (int i = 1; i < 6; i++) alloc(28'h1000000 + 28'(i));
        for (int i = 5; i >= 0; i--) complete(4'(i), 28'h1000000 + 28'(i));
        complete(4'd0, 28'h0BADBAD);
        check("dup_data", 32'(bus.retire_data_o), 32'h1000000);
        bus.retire_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) step();
        bus.retire_ready_i = 1'b0;
        check("rej_empty", 32'(bus.empty_rob_o), 1);
        check("rej_sb", 32'(exp_q.size()), 0);
        // wrap-around stream: allocate, complete previous, retire continuously
        do_reset();
        bus.retire_ready_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wdat[i] = 28'(i * 32'h0111111 + 7);
            exp_q.push_back(wdat[i]);
            bus.wr0_en_i = 1'b1;
            bus.wr1_en_i = (i > 0);
            bus.wr1_addr_i = 4'((i + 15) % 16);
            bus.wr1_data_i = (i > 0) ? wdat[i-1] : '0;
            step();
            check("wrap_full", 32'(bus.full_rob_o), 0);
        end
        bus.wr0_en_i = 1'b0;
        complete(4'(39 % 16), wdat[39]);
        step();
        step();
        check("wrap_empty", 32'(bus.empty_rob_o), 1);
        check("wrap_head", 32'(bus.head_addr_o), 32'(40 % 16));
        check("wrap_sb", 32'(exp_q.size()), 0);
        bus.retire_ready_i = 1'b0;
        // reset mid-stream discards in-flight entries
        alloc(28'h7777777);
        alloc(28'h8888888);
        complete(4'(40 % 16), 28'h7777777);
        bus.wr0_en_i = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.wr0_en_i = 1'b0;
        exp_q.delete();
        check("mrst_empty", 32'(bus.empty_rob_o), 1);
        check("mrst_head", 32'(bus.head_addr_o), 0);
        check("mrst_valid", 32'(bus.retire_valid_o), 0);
        check("mrst_err", 32'(bus.err_o), 0);
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/rob_queue.md
ROB_QUEUE -- requirements
Module: rob_queue

Interface
REQ-001 Parameter rob_num, default 16, number of entries (power of 2, >=2); rob_width = ceil(log2(rob_num)).
REQ-002 Parameter rob_data_length, default 28, completion/retire record width.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 wr0_en_i  in  1  allocate one entry at head_addr_o (from decode).
REQ-006 head_addr_o  out  rob_width  index the next allocation receives.
REQ-007 full_rob_o  out  1  all rob_num entries allocated.
REQ-008 wr1_en_i  in  1  completion write (from execute).
REQ-009 wr1_addr_i  in  rob_width  entry being completed.
REQ-010 wr1_data_i  in  rob_data_length  completion record.
REQ-011 retire_valid_o  out  1  oldest entry complete and presented.
REQ-012 retire_data_o  out  rob_data_length  record of oldest entry.
REQ-013 retire_ready_i  in  1  consumer accepts retire record.
REQ-014 empty_rob_o  out  1  no entries allocated.
REQ-015 err_o  out  1  sticky protocol-error flag (see Configuration).

Function
REQ-016 State: circular array of rob_num records, per-entry alloc and done bits, head pointer (allocation), tail pointer (oldest), count of width rob_width+1.
REQ-017 Allocation: wr0_en_i && !full_rob_o at edge -> entry[head] alloc=1, done=0; head increments modulo rob_num; count+1.
REQ-018 wr0_en_i while full_rob_o=1 SHALL be ignored: no pointer, count or entry change.
REQ-019 Completion: wr1_en_i with alloc[wr1_addr_i]=1 and done=0 -> record stored, done=1 at next edge.
REQ-020 Completion to an entry with alloc=0 or done=1 SHALL be ignored (record and bits unchanged).
REQ-021 Completion in the same cycle as that entry's allocation SHALL be ignored (alloc seen is pre-edge value).
REQ-022 retire_valid_o = (count!=0) && done[tail]; retire_data_o = record[tail]; both driven from registers only, no combinational path from any input.
REQ-023 Retire: retire_valid_o && retire_ready_i at edge -> alloc[tail]=0, done[tail]=0, tail increments modulo rob_num, count-1.
REQ-024 Completion-to-retire latency: completion of the oldest entry at edge N -> retire_valid_o high after edge N.
REQ-025 Retirement strictly in allocation order; a completed younger entry SHALL NOT retire before an incomplete older one.
REQ-026 Simultaneous allocate and retire: both take effect, count unchanged; legal also when full (retire frees slot, allocation still rejected that cycle per REQ-018 pre-edge full).
REQ-027 full_rob_o = (count==rob_num); empty_rob_o = (count==0); head_addr_o = head; all registered-state derived.
REQ-028 retire_valid_o SHALL stay high with stable retire_data_o until accepted.

Reset
REQ-029 rst=1 at edge: head=0, tail=0, count=0, all alloc/done=0, err_o=0; records need no reset.
REQ-030 Post-reset outputs: head_addr_o=0, full_rob_o=0, empty_rob_o=1, retire_valid_o=0, retire_data_o don't-care.
REQ-031 rst mid-operation discards all in-flight entries; rst has priority over all inputs that cycle.

Configuration
REQ-032 Macro ROB_QUEUE_ERR_CHK_EN defined: err_o sets (sticky until rst) on wr0_en_i while full, or on completion rejected by REQ-020.
REQ-033 Macro undefined: err_o constant 0, checking logic absent; all other behaviour identical.

Verification
REQ-034 Reset, then 16 allocations on consecutive cycles -> head_addr_o 0..15 then 0, full_rob_o=1 after 16th edge; 17th wr0_en_i ignored, err_o=1 only with macro.
REQ-035 Allocate 3 (entries 0,1,2), complete 2 then 1 -> retire_valid_o stays 0; complete 0 -> retire_valid_o=1 next cycle, with ready=1 retires 0,1,2 on three consecutive cycles, empty_rob_o=1 after.
REQ-036 Oldest complete, retire_ready_i=0 for 5 cycles -> retire_valid_o=1 and retire_data_o unchanged throughout; accepted on ready=1.
REQ-037 Full queue, entry tail done, wr0_en_i=1 and retire_ready_i=1 same cycle -> count 15, full_rob_o=0, head unchanged; next-cycle wr0_en_i accepted.
REQ-038 Completion to unallocated entry 5 (data 0xABC) -> no state change, later retire of entry 5 shows its own completion data, err_o=1 with macro, 0 without.
REQ-039 Wrap-around: 40 allocate/complete/retire cycles with rob_num=16 -> records retire in allocation order, count never exceeds 16; rst asserted mid-stream -> empty_rob_o=1, head_addr_o=0 next cycle.
